// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder.
// The state encoding is shared so the top-level FSM and any debug logic agree.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] DEFAULT_DEV_ID = 8'h42;
  localparam logic       ACK            = 1'b0;
  localparam logic       NACK           = 1'b1;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes sioc/siod into the clk domain and flags clock edges plus
// START/STOP conditions on the synchronized lines.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sioc_i,
  input  logic siod_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], sioc_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], siod_i};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Reset to the idle-bus level so leaving reset never looks like a START.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB/I2C target: decodes ID/register/data frames, acknowledges, emits
// register-write strobes and serves reads from an external register file.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = DEFAULT_DEV_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sioc,
  inout  wire        siod,
  output logic       wr_valid,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       id_miss
);

  logic scl_rise, scl_fall, sda_s, start, stop;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .sioc_i   (sioc),
    .siod_i   (siod),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start    (start),
    .stop     (stop)
  );

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       oe_q, oe_d;
  logic       rw_q, rw_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic [7:0] wr_reg_q, wr_reg_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_valid_q, wr_valid_d;
  logic       busy_q, busy_d;
  logic       id_miss_q, id_miss_d;
  logic [7:0] byte_in;
  logic       last_bit;

  assign byte_in  = {shift_q[6:0], sda_s};
  assign last_bit = (cnt_q == 4'd7);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    oe_d       = oe_q;
    rw_d       = rw_q;
    rd_addr_d  = rd_addr_q;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    busy_d     = busy_q;
    id_miss_d  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = ST_ID;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_ID: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (last_bit) begin
            cnt_d = 4'd0;
            if (byte_in[7:1] == DEV_ID[7:1]) begin
              rw_d    = byte_in[0];
              state_d = ST_ID_ACK;
            end else begin
              id_miss_d = 1'b1;
              state_d   = ST_IGNORE;
            end
          end
        end
        // oe_q doubles as the ACK-slot phase: first fall drives, second releases.
        ST_ID_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else if (rw_q) begin
            shift_d = rd_data;
            oe_d    = ~rd_data[7];
            cnt_d   = 4'd0;
            state_d = ST_RDATA;
          end else begin
            oe_d    = 1'b0;
            state_d = ST_REG;
          end
        end
        ST_REG: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (last_bit) begin
            cnt_d     = 4'd0;
            rd_addr_d = byte_in;
            state_d   = ST_REG_ACK;
          end
        end
        ST_REG_ACK, ST_WDATA_ACK: if (scl_fall) begin
          oe_d = ~oe_q;
          if (oe_q) state_d = ST_WDATA;
        end
        ST_WDATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (last_bit) begin
            cnt_d      = 4'd0;
            wr_valid_d = 1'b1;
            wr_reg_d   = rd_addr_q;
            wr_data_d  = byte_in;
            rd_addr_d  = rd_addr_q + 8'd1;
            state_d    = ST_WDATA_ACK;
          end
        end
        // The bit being presented is shift_q[7]; after eight rises the byte is done.
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = ST_RD_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == ACK) rd_addr_d = rd_addr_q + 8'd1;
            else              state_d   = ST_IGNORE;
          end else if (scl_fall) begin
            shift_d = rd_data;
            oe_d    = ~rd_data[7];
            cnt_d   = 4'd0;
            state_d = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      oe_q       <= 1'b0;
      rw_q       <= 1'b0;
      rd_addr_q  <= 8'd0;
      wr_reg_q   <= 8'd0;
      wr_data_q  <= 8'd0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      id_miss_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      oe_q       <= oe_d;
      rw_q       <= rw_d;
      rd_addr_q  <= rd_addr_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
      id_miss_q  <= id_miss_d;
    end
  end

  assign siod     = oe_q ? 1'b0 : 1'bz;
  assign wr_valid = wr_valid_q;
  assign wr_reg   = wr_reg_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = rd_addr_q;
  assign busy     = busy_q;
  assign id_miss  = id_miss_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: a bit-banged SCCB master drives directed frames while
// a forked monitor checks every write strobe against a queue of expected strobes.
module tb_sccb_responder;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sioc = 1'b1;
  logic       sda_low = 1'b0;
  wire        siod;
  logic       wr_valid;
  logic [7:0] wr_reg, wr_data, rd_addr, rd_data;
  logic       busy, id_miss;

  int         vectors = 0;
  int         miscompares = 0;
  int         id_miss_cnt = 0;
  logic       dut_low_seen = 1'b0;
  logic [15:0] exp_q[$];

  pullup (siod);
  assign siod = sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  // Small external register file served to reads.
  always_comb begin
    rd_data = 8'h00;
    if (rd_addr == 8'h0A) rd_data = 8'h76;
    else if (rd_addr == 8'h0B) rd_data = 8'h3C;
  end

  sccb_responder #(.DEV_ID(8'h42), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .sioc     (sioc),
    .siod     (siod),
    .wr_valid (wr_valid),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .id_miss  (id_miss)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (id_miss) id_miss_cnt++;
      if (siod === 1'b0 && !sda_low) dut_low_seen = 1'b1;
      if (wr_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_strobe: got reg %0h data %0h, expected no strobe", wr_reg, wr_data);
        end else begin
          checkOutput("strobe", {wr_reg, wr_data}, exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic send_start();
    sda_low = 1'b0; #Q;
    sioc = 1'b1;    #Q;
    sda_low = 1'b1; #Q;
    sioc = 1'b0;    #Q;
  endtask

  task automatic send_stop();
    sda_low = 1'b1; #Q;
    sioc = 1'b1;    #Q;
    sda_low = 1'b0; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_low = ~b[i]; #Q;
      sioc = 1'b1;     #(2*Q);
      sioc = 1'b0;     #Q;
    end
  endtask

  task automatic get_ack(output logic a);
    sda_low = 1'b0; #Q;
    sioc = 1'b1;    #Q;
    a = siod;       #Q;
    sioc = 1'b0;    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8);
    get_ack(a);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] b, output logic rel);
    sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #Q; sioc = 1'b1;
      #Q; b[i] = siod;
      #Q; sioc = 1'b0;
    end
    #Q; sda_low = (m_ack == 1'b0);
    #Q; sioc = 1'b1;
    #Q; rel = siod;
    #Q; sioc = 1'b0;
    sda_low = 1'b0; #Q;
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input int n,
                               input logic exp_ack);
    logic [7:0] bytes [4];
    logic a;
    bytes = '{b0, b1, b2, b3};
    send_start();
    checkOutput({tag, "_busy_on"}, {15'd0, busy}, 16'd1);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[i], a);
      checkOutput($sformatf("%s_ack%0d", tag, i), {15'd0, a}, {15'd0, exp_ack});
    end
    send_stop();
    repeat (5) @(negedge clk);
    checkOutput({tag, "_busy_off"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rel, a;
    int         miss_before;

    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    checkOutput("rst_siod",  {15'd0, siod},     16'd1);
    checkOutput("rst_busy",  {15'd0, busy},     16'd0);
    checkOutput("rst_wr",    {wr_reg, wr_data}, 16'h0000);
    checkOutput("rst_addr",  {8'd0, rd_addr},   16'h0000);
    checkOutput("rst_flags", {14'd0, wr_valid, id_miss}, 16'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] single write 42/12/80");
    exp_q.push_back(16'h1280);
    applyStimulus("wr", 8'h42, 8'h12, 8'h80, 8'h00, 3, 1'b0);
    checkOutput("wr_hold", {wr_reg, wr_data}, 16'h1280);
    checkOutput("wr_addr", {8'd0, rd_addr}, 16'h0013);

    $display("[TB] id mismatch 60");
    miss_before  = id_miss_cnt;
    dut_low_seen = 1'b0;
    applyStimulus("miss", 8'h60, 8'h12, 8'h34, 8'h00, 3, 1'b1);
    checkOutput("miss_pulse", 16'(id_miss_cnt - miss_before), 16'd1);
    checkOutput("miss_nodrive", {15'd0, dut_low_seen}, 16'd0);
    checkOutput("miss_addr", {8'd0, rd_addr}, 16'h0013);

    $display("[TB] pointer set then read with NACK");
    applyStimulus("ptr", 8'h42, 8'h0A, 8'h00, 8'h00, 2, 1'b0);
    checkOutput("ptr_addr", {8'd0, rd_addr}, 16'h000A);
    send_start();
    send_byte(8'h43, a);
    checkOutput("rd_id_ack", {15'd0, a}, 16'd0);
    read_byte(1'b1, rb, rel);
    checkOutput("rd_byte", {8'd0, rb}, 16'h0076);
    checkOutput("rd_release", {15'd0, rel}, 16'd1);
    send_stop();
    repeat (5) @(negedge clk);
    checkOutput("rd_addr", {8'd0, rd_addr}, 16'h000A);

    $display("[TB] two-byte read with master ACK");
    send_start();
    send_byte(8'h43, a);
    read_byte(1'b0, rb, rel);
    checkOutput("rd2_byte0", {8'd0, rb}, 16'h0076);
    read_byte(1'b1, rb, rel);
    checkOutput("rd2_byte1", {8'd0, rb}, 16'h003C);
    send_stop();
    repeat (5) @(negedge clk);
    checkOutput("rd2_addr", {8'd0, rd_addr}, 16'h000B);

    $display("[TB] burst write with pointer wrap");
    exp_q.push_back(16'hFF11);
    exp_q.push_back(16'h0022);
    applyStimulus("burst", 8'h42, 8'hFF, 8'h11, 8'h22, 4, 1'b0);
    checkOutput("burst_addr", {8'd0, rd_addr}, 16'h0001);

    $display("[TB] repeated START mid data byte");
    send_start();
    send_byte(8'h42, a);
    send_byte(8'h05, a);
    send_bits(8'hA7, 4);
    exp_q.push_back(16'h055A);
    applyStimulus("rs", 8'h42, 8'h05, 8'h5A, 8'h00, 3, 1'b0);
    checkOutput("rs_addr", {8'd0, rd_addr}, 16'h0006);

    $display("[TB] reset inside ACK slot");
    send_start();
    send_bits(8'h42, 8);
    sda_low = 1'b0; #Q;
    sioc = 1'b1;    #Q;
    checkOutput("ackslot_drive", {15'd0, siod}, 16'd0);
    reset = 1'b1;
    #1;
    checkOutput("arst_siod", {15'd0, siod}, 16'd1);
    checkOutput("arst_outs", {wr_reg, wr_data}, 16'h0000);
    checkOutput("arst_misc", {6'd0, rd_addr, busy, wr_valid}, 16'h0000);
    #Q;
    sioc = 1'b0;
    reset = 1'b0;
    #Q;
    send_stop();
    exp_q.push_back(16'h3344);
    applyStimulus("post", 8'h42, 8'h33, 8'h44, 8'h00, 3, 1'b0);
    checkOutput("post_addr", {8'd0, rd_addr}, 16'h0034);

    repeat (10) @(negedge clk);
    checkOutput("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- Synthesizable SCCB/I2C target. Sits on the same `sioc`/`siod` bus as the camera-configuration master.
- Decodes START / ID / register / data / STOP frames, acknowledges, and emits register-write strobes.
- Serves read transactions from an external register file through `rd_addr`/`rd_data`.
- Used as an on-chip camera register model, both for loopback verification and for shadowing the written configuration.

Parameters:
- DEV_ID, 8'h42, 8-bit write address; the read address is DEV_ID | 1. Bit 0 of the parameter is ignored.
- SYNC_STAGES, 2, flip-flop stages on the `sioc`/`siod` inputs (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 16x the SCL rate.
- reset  input  1  asynchronous, active-high reset.
- sioc  input  1  serial clock from the master.
- siod  inout  1  serial data, open-drain. The block only drives 0 or 1'bz.
- wr_valid  output  1  one-cycle strobe: a data byte has been written.
- wr_reg  output  8  register address for `wr_valid`.
- wr_data  output  8  data byte for `wr_valid`.
- rd_addr  output  8  current register pointer.
- rd_data  input  8  read value for `rd_addr`; sampled at byte load.
- busy  output  1  high from START to STOP.
- id_miss  output  1  one-cycle strobe: the ID byte did not match.

Behaviour:
- Reset (async): state IDLE, `siod` released (Z), `wr_valid`=0, `wr_reg`=0, `wr_data`=0, `rd_addr`=0, `busy`=0, `id_miss`=0.
- Input conditioning: `sioc`/`siod` pass through SYNC_STAGES flip-flops, then a previous-value register.
  - `scl_rise` / `scl_fall` are edges of the synced `sioc`.
  - START = synced `siod` 1->0 while synced `sioc`=1.
  - STOP = synced `siod` 0->1 while synced `sioc`=1.
- Bit timing: data is sampled on `scl_rise`, MSB first. The drive enable changes only on `scl_fall`.
- States: IDLE, ID, ID_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE.
- START from any state: go to ID, clear the bit counter, release `siod`, `busy`=1. This covers repeated START.
- STOP from any state: go to IDLE, release `siod`, `busy`=0. STOP takes priority over a coincident edge.
- ID, after the 8th `scl_rise`:
  - byte[7:1]==DEV_ID[7:1]: go to ID_ACK.
  - Otherwise: pulse `id_miss`, go to IGNORE. Never drive the bus; stay until START/STOP.
- ACK slot: on the `scl_fall` after the 8th bit, drive `siod`=0. On the next `scl_fall`, release. This applies even though SCCB masters treat the 9th bit as don't-care.
- ID_ACK exit:
  - Write ID goes to REG.
  - Read ID loads the shift register from `rd_data` at the releasing `scl_fall` and goes to RDATA.
- REG byte: captured into `rd_addr`. REG_ACK then goes to WDATA.
- WDATA 8th bit:
  - In the next clk, `wr_valid`=1 for exactly one cycle, with `wr_reg`=`rd_addr` and `wr_data`=byte.
  - `wr_reg`/`wr_data` hold until the next strobe.
  - Then WDATA_ACK, then WDATA again for further bytes, with `rd_addr` incremented by 1 (8'hFF wraps to 8'h00).
- A 2-phase write (ID, REG, STOP) only sets `rd_addr`; no strobe.
- RDATA:
  - On each `scl_fall`, drive 0 if the current bit is 0, else release.
  - After the 8th bit's `scl_fall`, release and go to RD_ACK.
  - Master ACK (`siod`=0 at `scl_rise`): `rd_addr`+1, reload from `rd_data` on the following `scl_fall`, stay in RDATA.
  - Master NACK: go to IGNORE.
- A data bit changing while `sioc` is high outside START/STOP is impossible by construction; it is treated as START or STOP.
- Reset mid-transfer releases `siod` immediately (asynchronously).

Decomposition:
- Shared package `sccb_pkg`:
  - state encoding localparams.
  - DEFAULT_DEV_ID = 8'h42.
  - ACK = 1'b0, NACK = 1'b1.
- Sub-module `sccb_line_sync`: input synchronizer plus edge, START and STOP detection. Outputs: `scl_rise`, `scl_fall`, `sda_s`, `start`, `stop`.
- The top level holds the FSM, shift register, bit counter, pointer and `siod` tristate.

Test Plan:
- Write via the existing I2C sender (id 8'h42, reg 8'h12, value 8'h80) -> exactly one `wr_valid`, `wr_reg`=8'h12, `wr_data`=8'h80; responder pulls `siod` low in 3 ACK slots; `busy` falls after STOP.
- ID 8'h60 frame -> `id_miss` pulse, `siod` never driven, no `wr_valid`, `rd_addr` unchanged.
- Write 42/0A, STOP; START 43; `rd_data`=8'h76; master NACK -> bits 0,1,1,1,0,1,1,0 observed on `siod`; `siod` released after the 8th bit; `rd_addr`=8'h0A.
- Burst: 42, FF, data 11, 22 -> strobes (FF,11), then (00,22).
- Repeated START after 4 bits of the data byte -> no strobe, FSM in ID; the next full frame writes correctly.
- Assert `reset` during an ACK slot -> `siod`=Z in the same cycle, all outputs at reset values; the next frame works.
